// File: rtl/load_use_scoreboard_if.sv
// rtl/load_use_scoreboard_if.sv - ID-stage issue request and scoreboard response bundle
interface load_use_scoreboard_if #(
    parameter int REG_ADDRS_BITS = 5,
    parameter int LAT_BITS       = 3,
    parameter int CNT_BITS       = 16
);
    logic                         i_id_valid;
    logic [REG_ADDRS_BITS-1:0]    i_id_rs;
    logic [REG_ADDRS_BITS-1:0]    i_id_rt;
    logic                         i_id_uses_rs;
    logic                         i_id_uses_rt;
    logic                         i_id_RegWrite;
    logic [REG_ADDRS_BITS-1:0]    i_id_rd;
    logic [LAT_BITS-1:0]          i_id_latency;
    logic                         i_flush;
    logic                         o_stall;
    logic                         o_issue;
    logic [2**REG_ADDRS_BITS-1:0] o_pending;
    logic [CNT_BITS-1:0]          o_stall_count;

    // Pipeline control side drives the ID instruction and reads the verdict
    modport master (
        output i_id_valid, i_id_rs, i_id_rt, i_id_uses_rs, i_id_uses_rt,
        output i_id_RegWrite, i_id_rd, i_id_latency, i_flush,
        input  o_stall, o_issue, o_pending, o_stall_count
    );

    // Scoreboard side
    modport slave (
        input  i_id_valid, i_id_rs, i_id_rt, i_id_uses_rs, i_id_uses_rt,
        input  i_id_RegWrite, i_id_rd, i_id_latency, i_flush,
        output o_stall, o_issue, o_pending, o_stall_count
    );
endinterface

// File: rtl/load_use_scoreboard.sv
// rtl/load_use_scoreboard.sv - per-register countdown table stalling ID on long-latency results
module load_use_scoreboard #(
    parameter int REG_ADDRS_BITS = 5,
    parameter int LAT_BITS       = 3,
    parameter int CNT_BITS       = 16
) (
    input logic                i_clk,
    input logic                i_reset,
    load_use_scoreboard_if.slave bus
);
    localparam int NREGS = 2**REG_ADDRS_BITS;

    logic [LAT_BITS-1:0] cnt_q [NREGS];
    logic [LAT_BITS-1:0] cnt_d [NREGS];
    logic [CNT_BITS-1:0] stall_cnt_q;
    logic [CNT_BITS-1:0] stall_cnt_d;
    logic                hazard_rs;
    logic                hazard_rt;
    logic                stall;
    logic                issue;
    logic                wr_en;
    logic [NREGS-1:0]    pending;

    // Hazards look at the table as it stood after the last edge, so an
    // instruction's own write can never stall itself.
    always_comb begin
        hazard_rs = bus.i_id_uses_rs && (bus.i_id_rs != '0) && (cnt_q[bus.i_id_rs] != '0);
        hazard_rt = bus.i_id_uses_rt && (bus.i_id_rt != '0) && (cnt_q[bus.i_id_rt] != '0);
        stall     = bus.i_id_valid && !bus.i_flush && (hazard_rs || hazard_rt);
        issue     = bus.i_id_valid && !bus.i_flush && !stall;
        wr_en     = issue && bus.i_id_RegWrite && (bus.i_id_rd != '0) && (bus.i_id_latency != '0);
    end

    // Newest producer replaces any outstanding count; everything else drains
    // by one per cycle regardless of stall or flush.
    always_comb begin
        for (int r = 0; r < NREGS; r++) begin
            cnt_d[r] = cnt_q[r];
            if (wr_en && (bus.i_id_rd == REG_ADDRS_BITS'(r))) begin
                cnt_d[r] = bus.i_id_latency;
            end else if (cnt_q[r] != '0) begin
                cnt_d[r] = cnt_q[r] - LAT_BITS'(1);
            end
        end
    end

    // Saturating stall statistics
    always_comb begin
        stall_cnt_d = stall_cnt_q;
        if (stall && (stall_cnt_q != '1)) begin
            stall_cnt_d = stall_cnt_q + CNT_BITS'(1);
        end
    end

    // Table and counter registers
    always_ff @(posedge i_clk) begin
        if (i_reset) begin
            for (int r = 0; r < NREGS; r++) begin
                cnt_q[r] <= '0;
            end
            stall_cnt_q <= '0;
        end else begin
            for (int r = 0; r < NREGS; r++) begin
                cnt_q[r] <= cnt_d[r];
            end
            stall_cnt_q <= stall_cnt_d;
        end
    end

    // Pending vector straight from the registered table
    always_comb begin
        for (int r = 0; r < NREGS; r++) begin
            pending[r] = (cnt_q[r] != '0);
        end
    end

    assign bus.o_stall       = stall;
    assign bus.o_issue       = issue;
    assign bus.o_pending     = pending;
    assign bus.o_stall_count = stall_cnt_q;
endmodule

// File: tb/tb_load_use_scoreboard.sv
// tb/tb_load_use_scoreboard.sv - directed and randomized checks of load_use_scoreboard
module tb_load_use_scoreboard;
    logic i_clk;
    logic i_reset;
    int   compared;
    int   mismatched;

    load_use_scoreboard_if #(.REG_ADDRS_BITS(5), .LAT_BITS(3), .CNT_BITS(16)) bus ();

    load_use_scoreboard #(.REG_ADDRS_BITS(5), .LAT_BITS(3), .CNT_BITS(16)) dut (
        .i_clk   (i_clk),
        .i_reset (i_reset),
        .bus     (bus)
    );

    initial i_clk = 1'b0;
    always #5 i_clk = ~i_clk;

    // Reference: each register remembers the first cycle a reader may issue.
    longint      cyc;
    longint      ready [32];
    int unsigned m_count;
    logic        exp_stall;
    logic        exp_issue;
    logic [31:0] exp_pend;

    function automatic void model_eval();
        logic hrs, hrt;
        for (int r = 0; r < 32; r++) exp_pend[r] = (cyc < ready[r]);
        hrs = bus.i_id_uses_rs && (bus.i_id_rs != 0) && (cyc < ready[bus.i_id_rs]);
        hrt = bus.i_id_uses_rt && (bus.i_id_rt != 0) && (cyc < ready[bus.i_id_rt]);
        exp_stall = bus.i_id_valid && !bus.i_flush && (hrs || hrt);
        exp_issue = bus.i_id_valid && !bus.i_flush && !exp_stall;
    endfunction

    task automatic tick();
        model_eval();
        if (i_reset) begin
            for (int r = 0; r < 32; r++) ready[r] = 0;
            m_count = 0;
        end else begin
            if (exp_stall && m_count != 65535) m_count++;
            if (exp_issue && bus.i_id_RegWrite && bus.i_id_rd != 0 && bus.i_id_latency != 0)
                ready[bus.i_id_rd] = cyc + 1 + longint'(bus.i_id_latency);
        end
        @(posedge i_clk);
        cyc++;
        #1;
    endtask

    task automatic sample();
        @(negedge i_clk);
        model_eval();
    endtask

    task automatic set_id(input logic valid, input logic [4:0] rs, input logic urs,
                          input logic [4:0] rt, input logic urt, input logic rw,
                          input logic [4:0] rd, input logic [2:0] lat, input logic flush);
        bus.i_id_valid    = valid;
        bus.i_id_rs       = rs;
        bus.i_id_uses_rs  = urs;
        bus.i_id_rt       = rt;
        bus.i_id_uses_rt  = urt;
        bus.i_id_RegWrite = rw;
        bus.i_id_rd       = rd;
        bus.i_id_latency  = lat;
        bus.i_flush       = flush;
    endtask

    task automatic idle();
        set_id(1'b0, 5'd0, 1'b0, 5'd0, 1'b0, 1'b0, 5'd0, 3'd0, 1'b0);
    endtask

    task automatic test_reset();
        i_reset = 1'b1;
        idle();
        tick();
        tick();
        i_reset = 1'b0;
        sample();
        compared++; if (bus.o_stall !== 1'b0) begin mismatched++; $display("FAIL reset_stall got %b want 0", bus.o_stall); end
        compared++; if (bus.o_issue !== 1'b0) begin mismatched++; $display("FAIL reset_issue got %b want 0", bus.o_issue); end
        compared++; if (bus.o_pending !== 32'd0) begin mismatched++; $display("FAIL reset_pending got %h want 0", bus.o_pending); end
        compared++; if (bus.o_stall_count !== 16'd0) begin mismatched++; $display("FAIL reset_count got %0d want 0", bus.o_stall_count); end
    endtask

    task automatic test_alu();
        idle();
        tick();
        set_id(1'b1, 5'd1, 1'b1, 5'd2, 1'b1, 1'b1, 5'd3, 3'd0, 1'b0);
        sample();
        compared++; if (bus.o_issue !== 1'b1 || bus.o_stall !== 1'b0) begin mismatched++; $display("FAIL alu_issue got stall=%b issue=%b want 0/1", bus.o_stall, bus.o_issue); end
        tick();
        set_id(1'b1, 5'd3, 1'b1, 5'd0, 1'b0, 1'b0, 5'd0, 3'd0, 1'b0);
        sample();
        compared++; if (bus.o_stall !== 1'b0) begin mismatched++; $display("FAIL alu_reader_stall got %b want 0", bus.o_stall); end
        compared++; if (bus.o_pending !== 32'd0) begin mismatched++; $display("FAIL alu_pending got %h want 0", bus.o_pending); end
        tick();
    endtask

    task automatic test_load_use();
        set_id(1'b1, 5'd0, 1'b0, 5'd0, 1'b0, 1'b1, 5'd5, 3'd1, 1'b0);
        tick();
        set_id(1'b1, 5'd5, 1'b1, 5'd0, 1'b0, 1'b1, 5'd6, 3'd0, 1'b0);
        sample();
        compared++; if (bus.o_stall !== 1'b1) begin mismatched++; $display("FAIL load_use_stall got %b want 1", bus.o_stall); end
        compared++; if (bus.o_pending[5] !== 1'b1) begin mismatched++; $display("FAIL load_use_pending5 got %b want 1", bus.o_pending[5]); end
        tick();
        sample();
        compared++; if (bus.o_stall !== 1'b0 || bus.o_issue !== 1'b1) begin mismatched++; $display("FAIL load_use_issue got stall=%b issue=%b want 0/1", bus.o_stall, bus.o_issue); end
        tick();
        idle();
        sample();
        compared++; if (bus.o_stall_count !== 16'd1) begin mismatched++; $display("FAIL load_use_count got %0d want 1", bus.o_stall_count); end
    endtask

    task automatic test_multicycle();
        set_id(1'b1, 5'd0, 1'b0, 5'd0, 1'b0, 1'b1, 5'd7, 3'd4, 1'b0);
        tick();
        set_id(1'b1, 5'd0, 1'b0, 5'd7, 1'b1, 1'b0, 5'd0, 3'd0, 1'b0);
        for (int i = 0; i < 4; i++) begin
            sample();
            compared++; if (bus.o_stall !== 1'b1 || bus.o_pending[7] !== 1'b1) begin mismatched++; $display("FAIL multi_stall[%0d] got stall=%b pend7=%b want 1/1", i, bus.o_stall, bus.o_pending[7]); end
            tick();
        end
        sample();
        compared++; if (bus.o_issue !== 1'b1 || bus.o_pending[7] !== 1'b0) begin mismatched++; $display("FAIL multi_issue got issue=%b pend7=%b want 1/0", bus.o_issue, bus.o_pending[7]); end
        tick();
        idle();
        sample();
        compared++; if (bus.o_stall_count !== 16'd5) begin mismatched++; $display("FAIL multi_count got %0d want 5", bus.o_stall_count); end
    endtask

    task automatic test_r0();
        set_id(1'b1, 5'd0, 1'b0, 5'd0, 1'b0, 1'b1, 5'd0, 3'd1, 1'b0);
        tick();
        set_id(1'b1, 5'd0, 1'b1, 5'd0, 1'b1, 1'b0, 5'd0, 3'd0, 1'b0);
        sample();
        compared++; if (bus.o_stall !== 1'b0 || bus.o_issue !== 1'b1) begin mismatched++; $display("FAIL r0_reader got stall=%b issue=%b want 0/1", bus.o_stall, bus.o_issue); end
        compared++; if (bus.o_pending[0] !== 1'b0) begin mismatched++; $display("FAIL r0_pending got %b want 0", bus.o_pending[0]); end
        tick();
    endtask

    task automatic test_flush();
        set_id(1'b1, 5'd0, 1'b0, 5'd0, 1'b0, 1'b1, 5'd9, 3'd1, 1'b0);
        tick();
        set_id(1'b1, 5'd9, 1'b1, 5'd0, 1'b0, 1'b1, 5'd10, 3'd3, 1'b1);
        sample();
        compared++; if (bus.o_stall !== 1'b0 || bus.o_issue !== 1'b0) begin mismatched++; $display("FAIL flush_outputs got stall=%b issue=%b want 0/0", bus.o_stall, bus.o_issue); end
        tick();
        bus.i_flush = 1'b0;
        sample();
        compared++; if (bus.o_stall !== 1'b0 || bus.o_issue !== 1'b1) begin mismatched++; $display("FAIL flush_refetch got stall=%b issue=%b want 0/1", bus.o_stall, bus.o_issue); end
        compared++; if (bus.o_pending[10] !== 1'b0) begin mismatched++; $display("FAIL flush_no_write got %b want 0", bus.o_pending[10]); end
        tick();
        idle();
        tick();
        tick();
        tick();
    endtask

    task automatic test_overwrite();
        set_id(1'b1, 5'd0, 1'b0, 5'd0, 1'b0, 1'b1, 5'd2, 3'd4, 1'b0);
        tick();
        set_id(1'b1, 5'd0, 1'b0, 5'd0, 1'b0, 1'b1, 5'd2, 3'd1, 1'b0);
        tick();
        set_id(1'b1, 5'd2, 1'b1, 5'd0, 1'b0, 1'b0, 5'd0, 3'd0, 1'b0);
        sample();
        compared++; if (bus.o_stall !== 1'b1) begin mismatched++; $display("FAIL overwrite_stall got %b want 1", bus.o_stall); end
        tick();
        sample();
        compared++; if (bus.o_stall !== 1'b0 || bus.o_issue !== 1'b1) begin mismatched++; $display("FAIL overwrite_issue got stall=%b issue=%b want 0/1", bus.o_stall, bus.o_issue); end
        tick();
    endtask

    task automatic test_reset_mid_stall();
        set_id(1'b1, 5'd0, 1'b0, 5'd0, 1'b0, 1'b1, 5'd4, 3'd4, 1'b0);
        tick();
        set_id(1'b1, 5'd4, 1'b1, 5'd0, 1'b0, 1'b0, 5'd0, 3'd0, 1'b0);
        sample();
        compared++; if (bus.o_stall !== 1'b1) begin mismatched++; $display("FAIL midrst_pre_stall got %b want 1", bus.o_stall); end
        i_reset = 1'b1;
        tick();
        i_reset = 1'b0;
        sample();
        compared++; if (bus.o_stall !== 1'b0 || bus.o_issue !== 1'b1) begin mismatched++; $display("FAIL midrst_clear got stall=%b issue=%b want 0/1", bus.o_stall, bus.o_issue); end
        compared++; if (bus.o_pending !== 32'd0 || bus.o_stall_count !== 16'd0) begin mismatched++; $display("FAIL midrst_state got pend=%h cnt=%0d want 0/0", bus.o_pending, bus.o_stall_count); end
        tick();
    endtask

    task automatic test_random();
        for (int i = 0; i < 600; i++) begin
            i_reset = ($urandom_range(0, 99) == 0);
            set_id($urandom_range(0, 3) != 0,
                   5'($urandom_range(0, 7)), 1'($urandom),
                   5'($urandom_range(0, 7)), 1'($urandom),
                   $urandom_range(0, 3) != 0,
                   5'($urandom_range(0, 7)), 3'($urandom_range(0, 7)),
                   $urandom_range(0, 7) == 0);
            sample();
            compared++; if (bus.o_stall !== exp_stall) begin mismatched++; $display("FAIL rand_stall[%0d] got %b want %b", i, bus.o_stall, exp_stall); end
            compared++; if (bus.o_issue !== exp_issue) begin mismatched++; $display("FAIL rand_issue[%0d] got %b want %b", i, bus.o_issue, exp_issue); end
            compared++; if (bus.o_pending !== exp_pend) begin mismatched++; $display("FAIL rand_pending[%0d] got %h want %h", i, bus.o_pending, exp_pend); end
            compared++; if (bus.o_stall_count !== 16'(m_count)) begin mismatched++; $display("FAIL rand_count[%0d] got %0d want %0d", i, bus.o_stall_count, m_count); end
            tick();
        end
        i_reset = 1'b0;
    endtask

    initial begin
        compared   = 0;
        mismatched = 0;
        cyc        = 0;
        m_count    = 0;
        for (int r = 0; r < 32; r++) ready[r] = 0;
        i_reset = 1'b1;
        idle();
        #1;
        test_reset();
        test_alu();
        test_load_use();
        test_multicycle();
        test_r0();
        test_flush();
        test_overwrite();
        test_reset_mid_stall();
        test_random();
        $display("*** SUMMARY: %0d compared / %0d mismatched ***", compared, mismatched);
        $finish;
    end
endmodule
